// File: rtl/cr_auth_pkg.sv
// cr_auth_pkg: shared types, default key and response function for the
// challenge-response link (used by the client and the server-side checker).
package cr_auth_pkg;

    typedef enum logic [2:0] {
        CR_IDLE,
        CR_COMPUTE,
        CR_SEND,
        CR_WAIT,
        CR_LOCKED
    } cr_client_state_t;

    localparam logic [3:0] CR_KEY_DEFAULT = 4'b1100;

    // Generic 32-bit form so callers of any width up to 32 can share it
    function automatic logic [31:0] cr_response(input logic [31:0] challenge, input logic [31:0] key);
        return challenge ^ key;
    endfunction

endpackage

// File: rtl/cr_wait_timer.sv
// cr_wait_timer: counts cycles while enabled and flags expiry in the
// TIMEOUT-th enabled cycle; clear returns the count to zero.
module cr_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = en && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = clear ? '0 : (en && !expired) ? cnt_q + CW'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/challenge_response_client.sv
// challenge_response_client: token-side responder; answers challenge ^ key,
// counts consecutive failures and locks out. Optional macro CR_CLIENT_TIMEOUT_EN.
import cr_auth_pkg::*;

module challenge_response_client #(
    parameter int           W        = 4,
    parameter logic [W-1:0] KEY_INIT = W'(CR_KEY_DEFAULT),
    parameter int           MAX_FAIL = 3,
    parameter int           TIMEOUT  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          chal_valid,
    input  logic [W-1:0]                  challenge,
    output logic                          chal_ready,
    output logic [W-1:0]                  response,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    input  logic                          auth_valid,
    input  logic                          auth_ok,
    output logic                          auth_pass,
    input  logic                          key_load,
    input  logic [W-1:0]                  key_in,
    input  logic                          clear_lock,
    output logic                          locked,
    output logic                          busy,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_count
);

    localparam int FW = $clog2(MAX_FAIL + 1);

    cr_client_state_t state_q, state_d;
    logic [W-1:0]     chal_q, chal_d;
    logic [W-1:0]     resp_q, resp_d;
    logic [W-1:0]     key_q, key_d;
    logic [FW-1:0]    fail_q, fail_d, fail_inc;
    logic             pass_q, pass_d;
    logic             timeout;

`ifdef CR_CLIENT_TIMEOUT_EN
    cr_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != CR_WAIT),
        .en      (state_q == CR_WAIT),
        .expired (timeout)
    );
`else
    // No timer: WAIT ends only on a verdict (the expression is constant false)
    assign timeout = (TIMEOUT < 0);
`endif

    assign fail_inc = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + FW'(1);

    always_comb begin
        state_d = state_q;
        chal_d  = chal_q;
        resp_d  = resp_q;
        key_d   = key_q;
        fail_d  = fail_q;
        pass_d  = 1'b0;
        if (key_load && (state_q == CR_IDLE || state_q == CR_LOCKED))
            key_d = key_in;
        case (state_q)
            CR_IDLE: begin
                if (chal_valid) begin
                    chal_d  = challenge;
                    state_d = CR_COMPUTE;
                end
            end
            CR_COMPUTE: begin
                resp_d  = W'(cr_response(32'(chal_q), 32'(key_q)));
                state_d = CR_SEND;
            end
            CR_SEND: begin
                if (resp_ready) state_d = CR_WAIT;
            end
            CR_WAIT: begin
                // A real verdict wins over a timeout in the same cycle
                if (auth_valid && auth_ok) begin
                    fail_d  = '0;
                    pass_d  = 1'b1;
                    state_d = CR_IDLE;
                end else if (auth_valid || timeout) begin
                    fail_d  = fail_inc;
                    state_d = (fail_inc == FW'(MAX_FAIL)) ? CR_LOCKED : CR_IDLE;
                end
            end
            CR_LOCKED: begin
                if (clear_lock) begin
                    fail_d  = '0;
                    state_d = CR_IDLE;
                end
            end
            default: state_d = CR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CR_IDLE;
            chal_q  <= '0;
            resp_q  <= '0;
            key_q   <= KEY_INIT;
            fail_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chal_q  <= chal_d;
            resp_q  <= resp_d;
            key_q   <= key_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    assign chal_ready = (state_q == CR_IDLE);
    assign resp_valid = (state_q == CR_SEND);
    assign response   = resp_q;
    assign auth_pass  = pass_q;
    assign locked     = (state_q == CR_LOCKED);
    assign busy       = (state_q == CR_COMPUTE) || (state_q == CR_SEND) || (state_q == CR_WAIT);
    assign fail_count = fail_q;

endmodule

// File: tb/tb_challenge_response_client.sv
// tb_challenge_response_client: directed plus randomized transactions checked
// against a transaction-level model of key, failure count and lockout.
module tb_challenge_response_client;

    localparam int           W        = 4;
    localparam int           MAX_FAIL = 3;
    localparam int           TIMEOUT  = 16;
    localparam logic [W-1:0] KEY_INIT = 4'b1100;
    localparam int           FW       = $clog2(MAX_FAIL + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          chal_valid = 1'b0;
    logic [W-1:0]  challenge = '0;
    logic          chal_ready;
    logic [W-1:0]  response;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic          auth_valid = 1'b0;
    logic          auth_ok = 1'b0;
    logic          auth_pass;
    logic          key_load = 1'b0;
    logic [W-1:0]  key_in = '0;
    logic          clear_lock = 1'b0;
    logic          locked;
    logic          busy;
    logic [FW-1:0] fail_count;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] m_key;
    int m_fail;

    challenge_response_client #(
        .W(W), .KEY_INIT(KEY_INIT), .MAX_FAIL(MAX_FAIL), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .chal_valid(chal_valid), .challenge(challenge), .chal_ready(chal_ready),
        .response(response), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .auth_valid(auth_valid), .auth_ok(auth_ok), .auth_pass(auth_pass),
        .key_load(key_load), .key_in(key_in), .clear_lock(clear_lock),
        .locked(locked), .busy(busy), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Key load attempt while busy: always a different key, must be ignored
    task automatic key_noise();
        key_load = 1'b1;
        key_in   = m_key ^ W'($urandom_range(1, 15));
    endtask

    // verdict: 0 = fail, 1 = pass, 2 = none (timeout or indefinite wait)
    task automatic txn(input logic [W-1:0] ch, input bit kl, input logic [W-1:0] kv,
                       input int rr_wait, input int v_wait, input int verdict);
        logic [W-1:0] exp;
        bit pass_exp;
        chk("idle_ready", chal_ready, 1);
        chal_valid = 1'b1;
        challenge  = ch;
        key_load   = kl;
        key_in     = kv;
        auth_valid = 1'($urandom_range(0, 1));
        auth_ok    = 1'b0;
        if (kl) m_key = kv;
        exp = ch ^ m_key;
        tick();
        chal_valid = 1'b0;
        auth_valid = 1'b0;
        challenge  = W'($urandom);
        key_noise();
        chk("compute_busy", busy, 1);
        chk("compute_no_valid", resp_valid, 0);
        tick();
        for (int i = 0; i <= rr_wait; i++) begin
            chk("send_valid", resp_valid, 1);
            chk("send_response", response, exp);
            chk("send_chal_ready", chal_ready, 0);
            key_noise();
            if (i == rr_wait) begin
                resp_ready = 1'b1;
                auth_valid = 1'($urandom_range(0, 1));
                auth_ok    = 1'b1;
            end
            tick();
        end
        resp_ready = 1'b0;
        auth_valid = 1'b0;
        chk("wait_busy", busy, 1);
        chk("wait_no_valid", resp_valid, 0);
        chk("wait_no_pass", auth_pass, 0);
        for (int i = 0; i < v_wait; i++) begin
            clear_lock = 1'($urandom_range(0, 1));
            key_noise();
            tick();
            chk("wait_hold", busy, 1);
        end
        clear_lock = 1'b0;
        key_load   = 1'b0;
        if (verdict == 2) begin
`ifdef CR_CLIENT_TIMEOUT_EN
            for (int i = v_wait + 1; i < TIMEOUT; i++) begin
                tick();
                chk("timeout_wait", busy, 1);
            end
            tick();
            pass_exp = 1'b0;
            m_fail++;
`else
            repeat (100) tick();
            chk("no_timeout_busy", busy, 1);
            chk("no_timeout_fail", fail_count, m_fail);
            auth_valid = 1'b1;
            auth_ok    = 1'b1;
            tick();
            auth_valid = 1'b0;
            pass_exp   = 1'b1;
            m_fail     = 0;
`endif
        end else begin
            auth_valid = 1'b1;
            auth_ok    = (verdict == 1);
            tick();
            auth_valid = 1'b0;
            pass_exp   = (verdict == 1);
            m_fail     = pass_exp ? 0 : m_fail + 1;
        end
        chk("verdict_pass", auth_pass, pass_exp);
        chk("verdict_fail_count", fail_count, m_fail);
        chk("verdict_locked", locked, m_fail == MAX_FAIL);
        chk("verdict_chal_ready", chal_ready, m_fail != MAX_FAIL);
        chk("verdict_not_busy", busy, 0);
        tick();
        chk("pass_one_cycle", auth_pass, 0);
        if (m_fail == MAX_FAIL) begin
            for (int i = 0; i < 3; i++) begin
                chal_valid = 1'b1;
                challenge  = W'($urandom);
                auth_valid = 1'($urandom_range(0, 1));
                key_load   = 1'($urandom_range(0, 1));
                key_in     = W'($urandom);
                if (key_load) m_key = key_in;
                tick();
                chk("locked_hold", locked, 1);
                chk("locked_chal_ready", chal_ready, 0);
                chk("locked_not_busy", busy, 0);
                chk("locked_fail_count", fail_count, MAX_FAIL);
            end
            chal_valid = 1'b0;
            auth_valid = 1'b0;
            key_load   = 1'b0;
            clear_lock = 1'b1;
            tick();
            clear_lock = 1'b0;
            m_fail     = 0;
            chk("clear_unlocked", locked, 0);
            chk("clear_fail_count", fail_count, 0);
            chk("clear_chal_ready", chal_ready, 1);
        end
    endtask

    initial begin
        m_key  = KEY_INIT;
        m_fail = 0;
        tick();
        tick();
        chk("rst_chal_ready", chal_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_response", response, 0);
        chk("rst_auth_pass", auth_pass, 0);
        chk("rst_locked", locked, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fail_count", fail_count, 0);
        reset = 1'b0;
        tick();

        txn(4'b1010, 1'b0, '0, 0, 0, 1);
        txn(4'b0011, 1'b0, '0, 5, 2, 1);
        txn(4'b1111, 1'b0, '0, 0, 1, 0);
        txn(4'b0001, 1'b0, '0, 1, 0, 0);
        txn(4'b1000, 1'b0, '0, 2, 3, 0);
        txn(4'b0101, 1'b1, 4'b0011, 1, 0, 1);
        txn(4'b1001, 1'b0, '0, 0, 0, 2);

        // Reset in SEND after a key change and a recorded failure
        txn(4'b0110, 1'b1, 4'b0111, 0, 0, 0);
        chal_valid = 1'b1;
        challenge  = 4'b0010;
        tick();
        chal_valid = 1'b0;
        tick();
        chk("pre_reset_send", resp_valid, 1);
        reset = 1'b1;
        #1;
        chk("async_rst_resp_valid", resp_valid, 0);
        chk("async_rst_response", response, 0);
        chk("async_rst_fail_count", fail_count, 0);
        chk("async_rst_chal_ready", chal_ready, 1);
        tick();
        reset  = 1'b0;
        m_key  = KEY_INIT;
        m_fail = 0;
        tick();
        txn(4'b0110, 1'b0, '0, 0, 0, 1);

        for (int n = 0; n < 30; n++) begin
            txn(W'($urandom), $urandom_range(0, 3) == 0, W'($urandom),
                $urandom_range(0, 4), $urandom_range(0, 6),
                ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
